// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and entry layout.
package rob_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = 4;
    localparam int ARCH_W    = 5;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              dest;
        logic [ARCH_W-1:0] addr;
    } rob_entry_t;
endpackage

// File: rtl/rob_retire_select.sv
// Picks up to two in-order retirements from the head and head+1 entries.
// Latency: combinational.
// Backpressure: none; younger slot retires only behind an older retire.
module rob_retire_select
    import rob_pkg::*;
(
    input  rob_entry_t        i_head,
    input  rob_entry_t        i_next,
    output logic              o_retire_A,
    output logic              o_retire_B,
    output logic              o_upd_en_A,
    output logic              o_upd_en_B,
    output logic [ARCH_W-1:0] o_upd_addr_A,
    output logic [ARCH_W-1:0] o_upd_addr_B
);
    assign o_retire_A   = i_head.valid & i_head.done;
    assign o_retire_B   = o_retire_A & i_next.valid & i_next.done;
    assign o_upd_en_A   = o_retire_A & i_head.dest;
    assign o_upd_en_B   = o_retire_B & i_next.dest;
    // Address is qualified so the register file never sees a stale index.
    assign o_upd_addr_A = o_upd_en_A ? i_head.addr : '0;
    assign o_upd_addr_B = o_upd_en_B ? i_next.addr : '0;
endmodule

// File: rtl/reorder_buffer.sv
// In-order 2-wide retire tracker driving the register-file commit port; ROB_FLUSH_EN adds a flush input.
// Latency: completion edge to updateEn high is 2 edges; retire outputs are registered 1-cycle pulses.
// Backpressure: alloc_ready drops when fewer than 2 entries are free; allocs while low are dropped.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              alloc_en_A,
    input  logic              alloc_en_B,
    input  logic              alloc_dest_A,
    input  logic              alloc_dest_B,
    input  logic [ARCH_W-1:0] alloc_addr_A,
    input  logic [ARCH_W-1:0] alloc_addr_B,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag_A,
    output logic [TAG_W-1:0]  alloc_tag_B,
    input  logic              cmpl_en_A,
    input  logic              cmpl_en_B,
    input  logic [TAG_W-1:0]  cmpl_tag_A,
    input  logic [TAG_W-1:0]  cmpl_tag_B,
    output logic              cmpl_err,
    output logic              updateEnA,
    output logic              updateEnB,
    output logic [ARCH_W-1:0] updateAddrA,
    output logic [ARCH_W-1:0] updateAddrB,
    output logic              rob_empty
);
    rob_entry_t        r_ent [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic [TAG_W-1:0]  w_head_p1;
    logic              w_acc_A;
    logic              w_acc_B;
    logic              w_hit_A;
    logic              w_hit_B;
    logic              w_err;
    logic              w_ret_A;
    logic              w_ret_B;
    logic              w_upd_en_A;
    logic              w_upd_en_B;
    logic [ARCH_W-1:0] w_upd_addr_A;
    logic [ARCH_W-1:0] w_upd_addr_B;
    logic [TAG_W:0]    w_n_alloc;
    logic [TAG_W:0]    w_n_ret;

    assign alloc_ready = (r_count <= (TAG_W+1)'(DEPTH - 2));
    assign rob_empty   = (r_count == '0);
    assign alloc_tag_A = r_tail;
    assign alloc_tag_B = r_tail + TAG_W'(alloc_en_A);
    assign w_head_p1   = r_head + TAG_W'(1);

    assign w_acc_A   = alloc_en_A & alloc_ready;
    assign w_acc_B   = alloc_en_B & alloc_ready;
    assign w_n_alloc = (TAG_W+1)'(w_acc_A) + (TAG_W+1)'(w_acc_B);
    assign w_n_ret   = (TAG_W+1)'(w_ret_A) + (TAG_W+1)'(w_ret_B);

    // Two ports hitting the same pending entry both see it pending, so no error.
    assign w_hit_A = r_ent[cmpl_tag_A].valid & ~r_ent[cmpl_tag_A].done;
    assign w_hit_B = r_ent[cmpl_tag_B].valid & ~r_ent[cmpl_tag_B].done;
    assign w_err   = (cmpl_en_A & ~w_hit_A) | (cmpl_en_B & ~w_hit_B);

    rob_retire_select u_sel (
        .i_head       (r_ent[r_head]),
        .i_next       (r_ent[w_head_p1]),
        .o_retire_A   (w_ret_A),
        .o_retire_B   (w_ret_B),
        .o_upd_en_A   (w_upd_en_A),
        .o_upd_en_B   (w_upd_en_B),
        .o_upd_addr_A (w_upd_addr_A),
        .o_upd_addr_B (w_upd_addr_B)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            updateEnA   <= 1'b0;
            updateEnB   <= 1'b0;
            updateAddrA <= '0;
            updateAddrB <= '0;
            cmpl_err    <= 1'b0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            updateEnA   <= 1'b0;
            updateEnB   <= 1'b0;
            updateAddrA <= '0;
            updateAddrB <= '0;
            cmpl_err    <= 1'b0;
        end
`endif
        else begin
            // Alloc slots are never live while alloc_ready is high, so these writes cannot collide.
            if (w_ret_A) r_ent[r_head]    <= '0;
            if (w_ret_B) r_ent[w_head_p1] <= '0;
            if (cmpl_en_A && w_hit_A) r_ent[cmpl_tag_A].done <= 1'b1;
            if (cmpl_en_B && w_hit_B) r_ent[cmpl_tag_B].done <= 1'b1;
            if (w_acc_A)
                r_ent[r_tail] <= '{valid: 1'b1, done: 1'b0, dest: alloc_dest_A, addr: alloc_addr_A};
            if (w_acc_B)
                r_ent[alloc_tag_B] <= '{valid: 1'b1, done: 1'b0, dest: alloc_dest_B, addr: alloc_addr_B};
            r_head      <= r_head + w_n_ret[TAG_W-1:0];
            r_tail      <= r_tail + w_n_alloc[TAG_W-1:0];
            r_count     <= r_count + w_n_alloc - w_n_ret;
            updateEnA   <= w_upd_en_A;
            updateEnB   <= w_upd_en_B;
            updateAddrA <= w_upd_addr_A;
            updateAddrB <= w_upd_addr_B;
            cmpl_err    <= w_err;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       flush;
    logic       alloc_en_A, alloc_en_B, alloc_dest_A, alloc_dest_B;
    logic [4:0] alloc_addr_A, alloc_addr_B;
    logic       alloc_ready;
    logic [3:0] alloc_tag_A, alloc_tag_B;
    logic       cmpl_en_A, cmpl_en_B;
    logic [3:0] cmpl_tag_A, cmpl_tag_B;
    logic       cmpl_err, updateEnA, updateEnB, rob_empty;
    logic [4:0] updateAddrA, updateAddrB;

    reorder_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef ROB_FLUSH_EN
        .flush        (flush),
`endif
        .alloc_en_A   (alloc_en_A),
        .alloc_en_B   (alloc_en_B),
        .alloc_dest_A (alloc_dest_A),
        .alloc_dest_B (alloc_dest_B),
        .alloc_addr_A (alloc_addr_A),
        .alloc_addr_B (alloc_addr_B),
        .alloc_ready  (alloc_ready),
        .alloc_tag_A  (alloc_tag_A),
        .alloc_tag_B  (alloc_tag_B),
        .cmpl_en_A    (cmpl_en_A),
        .cmpl_en_B    (cmpl_en_B),
        .cmpl_tag_A   (cmpl_tag_A),
        .cmpl_tag_B   (cmpl_tag_B),
        .cmpl_err     (cmpl_err),
        .updateEnA    (updateEnA),
        .updateEnB    (updateEnB),
        .updateAddrA  (updateAddrA),
        .updateAddrB  (updateAddrB),
        .rob_empty    (rob_empty)
    );

    // Model: in-flight instructions in program order.
    typedef struct {
        logic [3:0] tag;
        bit         done;
        bit         dest;
        logic [4:0] addr;
    } m_ent_t;

    m_ent_t     q[$];
    logic [3:0] next_tag;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pending(input logic [3:0] t);
        foreach (q[i]) if (q[i].tag == t && !q[i].done) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] pick_tag();
        if (q.size() > 0 && $urandom_range(0, 7) != 0)
            return q[$urandom_range(0, q.size() - 1)].tag;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic step(input bit aA, input bit aB, input bit dA, input bit dB,
                        input logic [4:0] adA, input logic [4:0] adB,
                        input bit cA, input bit cB, input logic [3:0] tA, input logic [3:0] tB,
                        input bit fl);
        bit         rdy, rA, rB, enA, enB, err;
        logic [4:0] exA, exB;
        logic [3:0] exp_tag_b;
        m_ent_t     e;
        @(negedge clk);
        alloc_en_A = aA; alloc_en_B = aB; alloc_dest_A = dA; alloc_dest_B = dB;
        alloc_addr_A = adA; alloc_addr_B = adB;
        cmpl_en_A = cA; cmpl_en_B = cB; cmpl_tag_A = tA; cmpl_tag_B = tB;
        flush = fl;
        #1;
        rdy       = (q.size() <= DEPTH - 2);
        exp_tag_b = next_tag + 4'(aA);
        check("alloc_ready", alloc_ready, rdy);
        check("alloc_tag_A", alloc_tag_A, next_tag);
        check("alloc_tag_B", alloc_tag_B, exp_tag_b);
        check("rob_empty", rob_empty, q.size() == 0);
        rA = 0; rB = 0; enA = 0; enB = 0; exA = 0; exB = 0; err = 0;
        if (fl) begin
            q.delete();
            next_tag = 0;
        end else begin
            if (q.size() > 0) rA = q[0].done;
            if (rA && q.size() > 1) rB = q[1].done;
            if (rA && q[0].dest) begin enA = 1; exA = q[0].addr; end
            if (rB && q[1].dest) begin enB = 1; exB = q[1].addr; end
            if (cA && !pending(tA)) err = 1;
            if (cB && !pending(tB)) err = 1;
            if (rA) void'(q.pop_front());
            if (rB) void'(q.pop_front());
            foreach (q[i]) if ((cA && q[i].tag == tA) || (cB && q[i].tag == tB)) q[i].done = 1;
            if (rdy && aA) begin
                e.tag = next_tag; e.done = 0; e.dest = dA; e.addr = adA;
                q.push_back(e); next_tag++;
            end
            if (rdy && aB) begin
                e.tag = next_tag; e.done = 0; e.dest = dB; e.addr = adB;
                q.push_back(e); next_tag++;
            end
        end
        @(posedge clk);
        #1;
        check("updateEnA", updateEnA, enA);
        check("updateEnB", updateEnB, enB);
        check("updateAddrA", updateAddrA, exA);
        check("updateAddrB", updateAddrB, exB);
        check("cmpl_err", cmpl_err, err);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 4'd0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alloc_en_A = 0; alloc_en_B = 0; cmpl_en_A = 0; cmpl_en_B = 0; flush = 0;
        @(posedge clk);
        #1;
        check("rst_alloc_ready", alloc_ready, 1'b1);
        check("rst_rob_empty", rob_empty, 1'b1);
        check("rst_updateEnA", updateEnA, 1'b0);
        check("rst_updateEnB", updateEnB, 1'b0);
        check("rst_cmpl_err", cmpl_err, 1'b0);
        check("rst_alloc_tag_A", alloc_tag_A, 4'd0);
        q.delete();
        next_tag = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit         rA_en, rB_en, rcA, rcB, rfl;
    logic [4:0] radA, radB;

    initial begin
        rst_n = 1'b0;
        alloc_en_A = 0; alloc_en_B = 0; alloc_dest_A = 0; alloc_dest_B = 0;
        alloc_addr_A = 0; alloc_addr_B = 0;
        cmpl_en_A = 0; cmpl_en_B = 0; cmpl_tag_A = 0; cmpl_tag_B = 0; flush = 0;
        q.delete();
        next_tag = 0;

        // Reset values
        do_reset();

        // Single path: r1 allocated at tag 0, retires one edge after its completion edge
        step(1, 0, 1, 0, 5'd1, 5'd0, 0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 0, 4'd0, 4'd0, 0);
        check("t2_no_early_retire", updateEnA, 1'b0);
        idle();
        check("t2_updEnA", updateEnA, 1'b1);
        check("t2_updAddrA", updateAddrA, 5'd1);
        idle();
        check("t2_updEnA_drop", updateEnA, 1'b0);
        check("t2_empty", rob_empty, 1'b1);

        // Dual retire, younger completes first
        do_reset();
        step(1, 1, 1, 1, 5'd3, 5'd4, 0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 0, 1, 4'd0, 4'd1, 0);
        idle();
        check("t3_hold_B", updateEnB, 1'b0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 0, 4'd0, 4'd0, 0);
        idle();
        check("t3_enA", updateEnA, 1'b1);
        check("t3_addrA", updateAddrA, 5'd3);
        check("t3_enB", updateEnB, 1'b1);
        check("t3_addrB", updateAddrB, 5'd4);
        idle();

        // Fill to 15, then to 16, then wrap
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 1, 1, 1, 5'(i), 5'(i + 8), 0, 0, 4'd0, 4'd0, 0);
        step(1, 0, 1, 0, 5'd20, 5'd0, 0, 0, 4'd0, 4'd0, 0);
        check("t4_ready_15", alloc_ready, 1'b0);
        step(1, 1, 1, 1, 5'd30, 5'd31, 0, 0, 4'd0, 4'd0, 0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 5'(i), 5'(i + 8), 0, 0, 4'd0, 4'd0, 0);
        check("t4_ready_16", alloc_ready, 1'b0);
        step(1, 1, 1, 1, 5'd30, 5'd31, 1, 1, 4'd0, 4'd1, 0);
        idle();
        check("t4_ready_after_retire", alloc_ready, 1'b1);
        check("t4_wrap_tag_A", alloc_tag_A, 4'd0);
        step(1, 1, 1, 1, 5'd17, 5'd18, 0, 0, 4'd0, 4'd0, 0);
        for (int i = 2; i < 16; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 1, 0, 4'(i), 4'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 1, 4'd0, 4'd1, 0);
        for (int i = 0; i < 4; i++) idle();
        check("t4_drained", rob_empty, 1'b1);

        // Error pulse and no-dest retire
        do_reset();
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 0, 4'd5, 4'd0, 0);
        check("t5_err_pulse", cmpl_err, 1'b1);
        idle();
        check("t5_err_clear", cmpl_err, 1'b0);
        step(1, 0, 0, 0, 5'd7, 5'd0, 0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 1, 4'd0, 4'd0, 0);
        check("t5_same_tag_no_err", cmpl_err, 1'b0);
        idle();
        check("t5_nodest_en", updateEnA, 1'b0);
        check("t5_nodest_addr", updateAddrA, 5'd0);
        check("t5_nodest_gone", rob_empty, 1'b1);

        // Asynchronous reset mid-retire drops outputs without a clock edge
        step(1, 0, 1, 0, 5'd9, 5'd0, 0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 0, 4'd1, 4'd0, 0);
        idle();
        check("t7_pre_rst_en", updateEnA, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t7_async_en", updateEnA, 1'b0);
        check("t7_async_addr", updateAddrA, 5'd0);
        check("t7_async_empty", rob_empty, 1'b1);
        q.delete();
        next_tag = 0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ROB_FLUSH_EN
        // Flush beats same-cycle alloc and completion
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 5'(i + 1), 5'(i + 4), 0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 1, 0, 4'd0, 4'd0, 0);
        step(1, 1, 1, 1, 5'd10, 5'd11, 1, 0, 4'd1, 4'd0, 1);
        check("t6_flush_empty", rob_empty, 1'b1);
        check("t6_flush_enA", updateEnA, 1'b0);
        check("t6_flush_tag", alloc_tag_A, 4'd0);
        idle();
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rA_en = ($urandom_range(0, 1) == 1);
            rB_en = ($urandom_range(0, 2) == 0);
            rcA   = ($urandom_range(0, 9) < 6);
            rcB   = ($urandom_range(0, 9) < 5);
            radA  = 5'($urandom_range(0, 31));
            radB  = 5'($urandom_range(0, 31));
`ifdef ROB_FLUSH_EN
            rfl   = ($urandom_range(0, 199) == 0);
`else
            rfl   = 1'b0;
`endif
            step(rA_en, rB_en, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 radA, radB, rcA, rcB, pick_tag(), pick_tag(), rfl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
